out_alu_control_unit: RTL and testbench

//  Return-path control unit between the ALU (adder and multiplier result ports) and FIFO_OUT.

---
 rtl/out_alu_control_unit.sv | 116 +++++++++++
 tb/tb_out_alu_control_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_alu_control_unit.sv
// out_alu_control_unit
// Return path from the ALU adder/multiplier result ports to FIFO_OUT.
// One result is accepted at a time into a holding register (round-robin
// between the two units when both finish together). The result is then
// written to FIFO_OUT as {result, id, op} with a single-cycle write pulse,
// and the write waits while FIFO_OUT is full.
// Optional build macro: OUT_CTRL_STATS_EN adds saturating add_cnt/mul_cnt
// counters of the ADD/MUL words written.
module out_alu_control_unit #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        a_valid_res,
  input  logic [DATA_SIZE-1:0]                        a_result,
  input  logic [ID_SIZE-1:0]                          a_id,
  output logic                                        a_ready_res,
  input  logic                                        m_valid_res,
  input  logic [DATA_SIZE-1:0]                        m_result,
  input  logic [ID_SIZE-1:0]                          m_id,
  output logic                                        m_ready_res,
  input  logic                                        full_out,
  output logic                                        w_en_out,
  output logic [DATA_SIZE+ID_SIZE+OPERATION_SIZE-1:0] fifo_wdata
`ifdef OUT_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                        add_cnt,
  output logic [CNT_WIDTH-1:0]                        mul_cnt
`endif
);

  localparam int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;
  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic {PRIO_ADD, PRIO_MUL} prio_t;

  state_t                    state, state_nx;
  prio_t                     prio, prio_nx;
  logic [FIFO_OUT_WIDTH-1:0] hold_reg, hold_nx;
  logic [FIFO_OUT_WIDTH-1:0] last_word, last_nx;
  logic                      write_slot;

  // State, holding register, arbitration priority and last written word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= PRIO_ADD;
      hold_reg  <= '0;
      last_word <= '0;
    end else begin
      state     <= state_nx;
      prio      <= prio_nx;
      hold_reg  <= hold_nx;
      last_word <= last_nx;
    end
  end

  // Readies, arbitration, capture of an accepted result and write decision
  always_comb begin
    state_nx    = state;
    prio_nx     = prio;
    hold_nx     = hold_reg;
    last_nx     = last_word;
    a_ready_res = 1'b0;
    m_ready_res = 1'b0;
    write_slot  = 1'b0;
    case (state)
      IDLE: begin
        a_ready_res = !m_valid_res || (prio == PRIO_ADD);
        m_ready_res = !a_valid_res || (prio == PRIO_MUL);
        if (a_valid_res && a_ready_res) begin
          hold_nx  = {a_result, a_id, OP_ADD};
          state_nx = HOLD;
          prio_nx  = PRIO_MUL;
        end else if (m_valid_res && m_ready_res) begin
          hold_nx  = {m_result, m_id, OP_MUL};
          state_nx = HOLD;
          prio_nx  = PRIO_ADD;
        end
      end
      HOLD: begin
        if (!full_out) begin
          write_slot = 1'b1;
          last_nx    = hold_reg;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A held result is dropped, never written, when reset is applied
  assign w_en_out   = write_slot && rst_n;
  assign fifo_wdata = w_en_out ? hold_reg : last_word;

`ifdef OUT_CTRL_STATS_EN
  // Saturating counts of ADD and MUL words handed to FIFO_OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_cnt <= '0;
      mul_cnt <= '0;
    end else if (w_en_out) begin
      if ((hold_reg[OPERATION_SIZE-1:0] == OP_ADD) && (add_cnt != {CNT_WIDTH{1'b1}}))
        add_cnt <= add_cnt + CNT_WIDTH'(1);
      if ((hold_reg[OPERATION_SIZE-1:0] == OP_MUL) && (mul_cnt != {CNT_WIDTH{1'b1}}))
        mul_cnt <= mul_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_out_alu_control_unit.sv
// Testbench for out_alu_control_unit: directed scenarios plus a randomized
// run checked against a queue-based reference model of the return path.
module tb_out_alu_control_unit;

  localparam int W     = 26;
  localparam int CNT_W = 2;

  logic          clk;
  logic          rst_n;
  logic          a_valid_res, m_valid_res, full_out;
  logic [15:0]   a_result, m_result;
  logic [7:0]    a_id, m_id;
  logic          a_ready_res, m_ready_res, w_en_out;
  logic [W-1:0]  fifo_wdata;
`ifdef OUT_CTRL_STATS_EN
  logic [CNT_W-1:0] add_cnt, mul_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: pending word queue (empty = nothing held)
  logic [W-1:0] mq[$];
  bit           mprio;
  logic [W-1:0] mlast;
  int           mcnt_add, mcnt_mul;

  out_alu_control_unit #(.DATA_SIZE(16), .ID_SIZE(8), .OPERATION_SIZE(2), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_res(a_valid_res), .a_result(a_result), .a_id(a_id), .a_ready_res(a_ready_res),
    .m_valid_res(m_valid_res), .m_result(m_result), .m_id(m_id), .m_ready_res(m_ready_res),
    .full_out(full_out), .w_en_out(w_en_out), .fifo_wdata(fifo_wdata)
`ifdef OUT_CTRL_STATS_EN
    , .add_cnt(add_cnt), .mul_cnt(mul_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_idle();
    return mq.size() == 0;
  endfunction

  function automatic bit m_a_rdy();
    return m_idle() && (!m_valid_res || mprio == 1'b0);
  endfunction

  function automatic bit m_m_rdy();
    return m_idle() && (!a_valid_res || mprio == 1'b1);
  endfunction

  function automatic bit m_wen();
    return !m_idle() && !full_out && rst_n;
  endfunction

  function automatic logic [W-1:0] m_data();
    return m_wen() ? mq[0] : mlast;
  endfunction

  task automatic drive(input bit av, input logic [15:0] ar, input logic [7:0] ai,
                       input bit mv, input logic [15:0] mr, input logic [7:0] mi,
                       input bit full, input bit rstn);
    a_valid_res = av; a_result = ar; a_id = ai;
    m_valid_res = mv; m_result = mr; m_id = mi;
    full_out = full; rst_n = rstn;
    #1;
  endtask

  task automatic advance(output bit acc_a, output bit acc_m);
    bit wen;
    logic [W-1:0] aw, mw;
    int maxc;
    maxc  = (1 << CNT_W) - 1;
    wen   = m_wen();
    acc_a = rst_n && a_valid_res && m_a_rdy();
    acc_m = rst_n && m_valid_res && m_m_rdy() && !acc_a;
    aw    = {a_result, a_id, 2'b01};
    mw    = {m_result, m_id, 2'b10};
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); mprio = 1'b0; mlast = '0; mcnt_add = 0; mcnt_mul = 0;
    end else begin
      if (wen) begin
        mlast = mq.pop_front();
        if (mlast[1:0] == 2'b01 && mcnt_add < maxc) mcnt_add++;
        if (mlast[1:0] == 2'b10 && mcnt_mul < maxc) mcnt_mul++;
      end
      if (acc_a) begin mq.push_back(aw); mprio = 1'b1; end
      else if (acc_m) begin mq.push_back(mw); mprio = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bit x, y;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance(x, y);
  endtask

  task automatic test_reset();
    bit x, y;
    do_reset();
    advance(x, y);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tests++; if (w_en_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_wen got=%b exp=0", w_en_out); end
    tests++; if (fifo_wdata !== '0) begin fails++; $display("[TB] FAIL reset_wdata got=%h exp=0", fifo_wdata); end
    tests++; if (a_ready_res !== 1'b1 || m_ready_res !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got=%b%b exp=11", a_ready_res, m_ready_res); end
`ifdef OUT_CTRL_STATS_EN
    tests++; if (add_cnt !== '0 || mul_cnt !== '0) begin fails++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0/0", add_cnt, mul_cnt); end
`endif
  endtask

  task automatic test_single_add();
    bit x, y;
    logic [W-1:0] exp_w;
    exp_w = {16'h0123, 8'h05, 2'b01};
    do_reset();
    drive(1, 16'h0123, 8'h05, 0, 0, 0, 0, 1);
    tests++; if (a_ready_res !== 1'b1) begin fails++; $display("[TB] FAIL add_ready got=%b exp=1", a_ready_res); end
    advance(x, y);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tests++; if (w_en_out !== 1'b1 || fifo_wdata !== exp_w) begin fails++; $display("[TB] FAIL add_write got=%b/%h exp=1/%h", w_en_out, fifo_wdata, exp_w); end
    advance(x, y);
    tests++; if (w_en_out !== 1'b0 || fifo_wdata !== exp_w) begin fails++; $display("[TB] FAIL add_after got=%b/%h exp=0/%h", w_en_out, fifo_wdata, exp_w); end
  endtask

  task automatic test_collision();
    bit x, y;
    logic [15:0] ar;
    logic [W-1:0] exp_a, exp_m;
    ar    = 16'($urandom);
    exp_a = {ar, 8'h11, 2'b01};
    exp_m = {16'h00E1, 8'h07, 2'b10};
    do_reset();
    drive(1, ar, 8'h11, 1, 16'h00E1, 8'h07, 0, 1);
    tests++; if (a_ready_res !== 1'b1 || m_ready_res !== 1'b0) begin fails++; $display("[TB] FAIL coll_arb got=%b%b exp=10", a_ready_res, m_ready_res); end
    advance(x, y);
    drive(0, 0, 0, 1, 16'h00E1, 8'h07, 0, 1);
    tests++; if (w_en_out !== 1'b1 || fifo_wdata !== exp_a || m_ready_res !== 1'b0) begin fails++; $display("[TB] FAIL coll_first got=%b/%h/%b exp=1/%h/0", w_en_out, fifo_wdata, m_ready_res, exp_a); end
    advance(x, y);
    tests++; if (m_ready_res !== 1'b1 || w_en_out !== 1'b0) begin fails++; $display("[TB] FAIL coll_mready got=%b/%b exp=1/0", m_ready_res, w_en_out); end
    advance(x, y);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tests++; if (w_en_out !== 1'b1 || fifo_wdata !== exp_m) begin fails++; $display("[TB] FAIL coll_second got=%b/%h exp=1/%h", w_en_out, fifo_wdata, exp_m); end
    advance(x, y);
    drive(1, 16'h1, 8'h1, 1, 16'h2, 8'h2, 0, 1);
    tests++; if (a_ready_res !== 1'b1 || m_ready_res !== 1'b0) begin fails++; $display("[TB] FAIL coll_prio_back got=%b%b exp=10", a_ready_res, m_ready_res); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_full_stall();
    bit x, y;
    logic [W-1:0] exp_w;
    exp_w = {16'hBEEF, 8'h3C, 2'b10};
    do_reset();
    drive(0, 0, 0, 1, 16'hBEEF, 8'h3C, 1, 1);
    advance(x, y);
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'h5555, 8'h66, 1, 16'h7777, 8'h88, 1, 1);
      tests++; if (w_en_out !== 1'b0 || a_ready_res !== 1'b0 || m_ready_res !== 1'b0) begin fails++; $display("[TB] FAIL stall_%0d got=%b%b%b exp=000", i, w_en_out, a_ready_res, m_ready_res); end
      advance(x, y);
    end
    drive(1, 16'h5555, 8'h66, 1, 16'h7777, 8'h88, 0, 1);
    tests++; if (w_en_out !== 1'b1 || fifo_wdata !== exp_w || a_ready_res !== 1'b0) begin fails++; $display("[TB] FAIL stall_release got=%b/%h/%b exp=1/%h/0", w_en_out, fifo_wdata, a_ready_res, exp_w); end
    advance(x, y);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tests++; if (w_en_out !== 1'b0) begin fails++; $display("[TB] FAIL stall_single_pulse got=%b exp=0", w_en_out); end
  endtask

  task automatic test_reset_mid_op();
    bit x, y;
    do_reset();
    drive(1, 16'hCAFE, 8'h42, 0, 0, 0, 1, 1);
    advance(x, y);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (w_en_out !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_wen got=%b exp=0", w_en_out); end
    advance(x, y);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      tests++; if (w_en_out !== 1'b0 || fifo_wdata !== '0 || a_ready_res !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_after_%0d got=%b/%h/%b exp=0/0/1", i, w_en_out, fifo_wdata, a_ready_res); end
      advance(x, y);
    end
  endtask

  task automatic test_random();
    bit ap, mp, acc_a, acc_m, full, rstn;
    logic [15:0] ar, mr;
    logic [7:0] ai, mi;
    ap = 0; mp = 0; ar = 0; mr = 0; ai = 0; mi = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!ap && $urandom_range(0, 2) == 0) begin ap = 1; ar = 16'($urandom); ai = 8'($urandom); end
      if (!mp && $urandom_range(0, 2) == 0) begin mp = 1; mr = 16'($urandom); mi = 8'($urandom); end
      full = ($urandom_range(0, 3) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      drive(ap, ar, ai, mp, mr, mi, full, rstn);
      tests++; if (a_ready_res !== m_a_rdy() || m_ready_res !== m_m_rdy()) begin fails++; $display("[TB] FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", i, a_ready_res, m_ready_res, m_a_rdy(), m_m_rdy()); end
      tests++; if (w_en_out !== m_wen() || fifo_wdata !== m_data()) begin fails++; $display("[TB] FAIL rand_write cyc=%0d got=%b/%h exp=%b/%h", i, w_en_out, fifo_wdata, m_wen(), m_data()); end
`ifdef OUT_CTRL_STATS_EN
      tests++; if (add_cnt !== CNT_W'(mcnt_add) || mul_cnt !== CNT_W'(mcnt_mul)) begin fails++; $display("[TB] FAIL rand_cnt cyc=%0d got=%h/%h exp=%0d/%0d", i, add_cnt, mul_cnt, mcnt_add, mcnt_mul); end
`endif
      advance(acc_a, acc_m);
      if (acc_a) ap = 0;
      if (acc_m) mp = 0;
    end
  endtask

`ifdef OUT_CTRL_STATS_EN
  task automatic test_stats();
    bit x, y;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 16'(i), 8'(i), 0, 0, 0, 0, 1);
      else       drive(0, 0, 0, 1, 16'h99, 8'h9, 0, 1);
      advance(x, y);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      advance(x, y);
    end
    tests++; if (add_cnt !== 2'b11 || mul_cnt !== 2'b01) begin fails++; $display("[TB] FAIL stats got=%b/%b exp=11/01", add_cnt, mul_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; a_valid_res = 0; m_valid_res = 0; full_out = 0;
    a_result = 0; a_id = 0; m_result = 0; m_id = 0;
    mprio = 0; mlast = '0; mcnt_add = 0; mcnt_mul = 0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_collision();
    test_full_stall();
    test_reset_mid_op();
    test_random();
`ifdef OUT_CTRL_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
